// File: rtl/spi_slave_frontend.sv
`timescale 1ns/1ps
// SPI mode-0 slave front end: brings SCK/CS_n/MOSI into the clk domain, deserializes
// a command byte followed by WORD_W-bit words, and serializes tx_data onto MISO.
module spi_slave_frontend #(
    parameter int WORD_W = 16,
    parameter int CMD_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [CMD_W-1:0]  cmd,
    output logic              done,
    output logic [WORD_W-1:0] rx_data,
    input  logic [WORD_W-1:0] tx_data,
    output logic              tx_load,
    output logic              abort
);

    localparam int               CNT_W     = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_W - 1);
    localparam logic [2:0]       SYNC_RST  = 3'b010;  // {sck, cs_n, mosi}

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t            state, state_nxt;
    logic [2:0]        sync1, sync2, hist;
    logic              sck_rise, sck_fall, cs_rise, cs_fall;
    logic [1:0]        warm;
    logic              armed;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [WORD_W-2:0] shift, shift_nxt;
    logic [WORD_W-1:0] shift_in, tx_shift, tx_nxt, rx_nxt;
    logic [CMD_W-1:0]  cmd_nxt;
    logic              done_nxt, load_nxt, abort_nxt, miso_nxt;
    logic              unit_end;

    // NOTE: every clocked block uses non-blocking assignments so all flops update
    // from pre-edge values; blocking here would collapse the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= SYNC_RST;
            sync2    <= SYNC_RST;
            hist     <= SYNC_RST;
            sck_rise <= 1'b0;
            sck_fall <= 1'b0;
            cs_rise  <= 1'b0;
            cs_fall  <= 1'b0;
        end else begin
            sync1    <= {spi_sck, spi_cs_n, spi_mosi};
            sync2    <= sync1;
            hist     <= sync2;
            sck_rise <= sync2[2] & ~hist[2];
            sck_fall <= ~sync2[2] & hist[2];
            cs_rise  <= sync2[1] & ~hist[1];
            cs_fall  <= ~sync2[1] & hist[1];
        end
    end

    // A frame may only start once a real (post-reset) high level on CS_n has been seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm  <= 2'b00;
            armed <= 1'b0;
        end else begin
            warm <= {warm[0], 1'b1};
            if (warm[1] && sync2[1])
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    assign shift_in = {shift, hist[0]};
    assign unit_end = sck_rise && (((state == CMD) && (cnt == CMD_LAST)) ||
                                   ((state == DATA) && (cnt == WORD_LAST)));

    // NOTE: each combinational output gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall && armed) state_nxt = CMD;
            CMD:     if (cs_rise) state_nxt = IDLE;
                     else if (unit_end) state_nxt = DATA;
            DATA:    if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt   = cnt;
        shift_nxt = shift;
        tx_nxt    = tx_shift;
        rx_nxt    = rx_data;
        cmd_nxt   = '0;
        done_nxt  = 1'b0;
        load_nxt  = 1'b0;
        abort_nxt = 1'b0;
        if (state == IDLE) begin
            cnt_nxt = '0;
        end else if (sck_rise) begin
            shift_nxt = shift_in[WORD_W-2:0];
            if (unit_end) begin
                cnt_nxt  = '0;
                tx_nxt   = tx_data;
                load_nxt = 1'b1;
                if (state == CMD) begin
                    cmd_nxt = shift_in[CMD_W-1:0];
                end else begin
                    rx_nxt   = shift_in;
                    done_nxt = 1'b1;
                end
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else if (sck_fall && (state == DATA) && (cnt != '0)) begin
            // Held at the word boundary so the next MSB stays on MISO through that fall.
            tx_nxt = {tx_shift[WORD_W-2:0], 1'b0};
        end
        if ((state != IDLE) && cs_rise) begin
            abort_nxt = (cnt_nxt != '0);
            cnt_nxt   = '0;
        end
        miso_nxt = (state_nxt == DATA) ? tx_nxt[WORD_W-1] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            shift    <= '0;
            tx_shift <= '0;
            rx_data  <= '0;
            cmd      <= '0;
            done     <= 1'b0;
            tx_load  <= 1'b0;
            abort    <= 1'b0;
            spi_miso <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            shift    <= shift_nxt;
            tx_shift <= tx_nxt;
            rx_data  <= rx_nxt;
            cmd      <= cmd_nxt;
            done     <= done_nxt;
            tx_load  <= load_nxt;
            abort    <= abort_nxt;
            spi_miso <= miso_nxt;
        end
    end

endmodule

// File: tb/tb_spi_slave_frontend.sv
`timescale 1ns/1ps
// Bench for spi_slave_frontend: table of SPI frames with hand-derived expectations,
// hand sequences for abort latency and mid-frame reset, then random frames vs a model.
module tb_spi_slave_frontend;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [3:0]  cmd;
    logic        done;
    logic [15:0] rx_data;
    logic [15:0] tx_data = '0;
    logic        tx_load;
    logic        abort;

    spi_slave_frontend #(.WORD_W(16), .CMD_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .cmd(cmd), .done(done),
        .rx_data(rx_data), .tx_data(tx_data), .tx_load(tx_load), .abort(abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       cb;
        int               cmd_bits;
        int               nw;
        int               cut;
        logic [2:0][15:0] w;
        logic [3:0][15:0] t;
        logic [3:0]       exp_cmd;
        int               exp_cmd_cyc;
        int               exp_done;
        int               exp_load;
        int               exp_abort;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cmd_cyc, done_cnt, load_cnt, abort_cyc;
    logic [3:0]  cmd_last;
    logic [15:0] rxq[$];
    logic [15:0] exp_rx = '0;
    vec_t        tbl[6];
    vec_t        v;
    logic [31:0] mw;
    int          lat;

    // Pulse monitor, sampled 1 ns after each active edge.
    always @(posedge clk) begin
        #1;
        if (cmd != 4'h0) begin cmd_cyc++; cmd_last = cmd; end
        if (done) begin done_cnt++; rxq.push_back(rx_data); end
        if (tx_load) load_cnt++;
        if (abort) abort_cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        cmd_cyc = 0; done_cnt = 0; load_cnt = 0; abort_cyc = 0; cmd_last = '0;
        rxq.delete();
    endtask

    // Mode 0: MOSI set while SCK low, MISO sampled just before the rising edge.
    task automatic send_bits(input logic [31:0] val, input int n, output logic [31:0] miso_word);
        miso_word = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = val[i];
            wait_neg(4);
            miso_word = {miso_word[30:0], spi_miso};
            spi_sck = 1'b1;
            wait_neg(4);
            spi_sck = 1'b0;
        end
    endtask

    function automatic vec_t mk(input logic [7:0] cb, input int bits, input int nw, input int cut,
                                input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                                input logic [15:0] t0, input logic [15:0] t1, input logic [15:0] t2,
                                input logic [3:0] ecmd, input int ecyc, input int edone,
                                input int eload, input int eabort);
        vec_t r;
        r.cb = cb; r.cmd_bits = bits; r.nw = nw; r.cut = cut;
        r.w = {w2, w1, w0};
        r.t = {16'h0000, t2, t1, t0};
        r.exp_cmd = ecmd; r.exp_cmd_cyc = ecyc; r.exp_done = edone;
        r.exp_load = eload; r.exp_abort = eabort;
        return r;
    endfunction

    // Reference: a full command byte yields its low nibble (visible only if nonzero),
    // one tx load for the byte plus one per word, and an abort for any partial unit.
    function automatic vec_t model(input vec_t in);
        vec_t r = in;
        bit full = (in.cmd_bits == 8);
        r.exp_cmd     = full ? (in.cb % 16) : 4'h0;
        r.exp_cmd_cyc = (full && (in.cb % 16) != 0) ? 1 : 0;
        r.exp_done    = in.nw;
        r.exp_load    = full ? in.nw + 1 : 0;
        r.exp_abort   = (!full || in.cut > 0) ? 1 : 0;
        return r;
    endfunction

    task automatic do_frame(input vec_t f);
        logic [31:0] m;
        tx_data  = f.t[0];
        spi_cs_n = 1'b0;
        wait_neg(8);
        send_bits({24'd0, f.cb} >> (8 - f.cmd_bits), f.cmd_bits, m);
        if (f.cmd_bits == 8) check("miso_during_cmd", m, 0);
        for (int w = 0; w < f.nw; w++) begin
            tx_data = f.t[w+1];
            send_bits({16'd0, f.w[w]}, 16, m);
            check("miso_word", m, {16'd0, f.t[w]});
        end
        if (f.cut > 0) send_bits($urandom, f.cut, m);
        wait_neg(4);
        spi_cs_n = 1'b1;
        wait_neg(12);
    endtask

    task automatic check_frame(input vec_t f);
        check("cmd_cycles", cmd_cyc, f.exp_cmd_cyc);
        if (f.exp_cmd_cyc != 0) check("cmd_value", cmd_last, f.exp_cmd);
        check("done_count", done_cnt, f.exp_done);
        for (int i = 0; i < rxq.size() && i < f.exp_done; i++)
            check("rx_word", rxq[i], f.w[i]);
        check("tx_load_count", load_cnt, f.exp_load);
        check("abort_cycles", abort_cyc, f.exp_abort);
        if (f.nw > 0) exp_rx = f.w[f.nw-1];
        check("rx_data_held", rx_data, exp_rx);
        check("miso_idle", spi_miso, 0);
    endtask

    task automatic run_vec(input vec_t f);
        clear_mon();
        do_frame(f);
        check_frame(f);
    endtask

    initial begin
        tbl[0] = mk(8'h02, 8, 0, 0, 16'h0, 16'h0, 16'h0, 16'hA5C3, 16'h0, 16'h0, 4'h2, 1, 0, 1, 0);
        tbl[1] = mk(8'h01, 8, 3, 0, 16'h1234, 16'hABCD, 16'hFFFF,
                    16'hA5C3, 16'h5A5A, 16'h8001, 4'h1, 1, 3, 4, 0);
        tbl[2] = mk(8'h01, 8, 1, 5, 16'h1111, 16'h0, 16'h0, 16'h0F0F, 16'hC33C, 16'h0, 4'h1, 1, 1, 2, 1);
        tbl[3] = mk(8'hF0, 8, 1, 0, 16'h0BEE, 16'h0, 16'h0, 16'h1357, 16'h0, 16'h0, 4'h0, 0, 1, 2, 0);
        tbl[4] = mk(8'hA7, 3, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0, 0, 0, 0, 1);
        tbl[5] = mk(8'h3C, 8, 2, 0, 16'h8000, 16'h0001, 16'h0,
                    16'hFFFF, 16'h0000, 16'h0, 4'hC, 1, 2, 3, 0);

        #1;
        check("reset_outputs", {spi_miso, cmd, done, rx_data, tx_load, abort}, 0);
        wait_neg(4);
        rst_n = 1'b1;
        wait_neg(8);

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // CS_n rises 5 bits into a word: abort on the 4th edge after the change.
        clear_mon();
        tx_data  = 16'h6C6C;
        spi_cs_n = 1'b0;
        wait_neg(8);
        send_bits(32'h01, 8, mw);
        send_bits(32'h2222, 16, mw);
        send_bits(32'h15, 5, mw);
        wait_neg(2);
        spi_cs_n = 1'b1;
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (abort) lat = i;
        end
        check("abort_latency_edges", lat, 4);
        wait_neg(8);
        check("abort_one_cycle", abort_cyc, 1);
        check("abort_done_count", done_cnt, 1);
        check("abort_rx_retained", rx_data, 16'h2222);
        exp_rx = 16'h2222;

        // Reset mid-word; a frame must not resume until CS_n has been high again.
        clear_mon();
        spi_cs_n = 1'b0;
        wait_neg(8);
        send_bits(32'h01, 8, mw);
        send_bits(32'h7F, 7, mw);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_outputs", {spi_miso, cmd, done, rx_data, tx_load, abort}, 0);
        exp_rx = '0;
        wait_neg(3);
        rst_n = 1'b1;
        wait_neg(4);
        clear_mon();
        send_bits(32'hFF, 8, mw);
        send_bits(32'hFFFF, 16, mw);
        wait_neg(8);
        check("no_resume_cmd", cmd_cyc, 0);
        check("no_resume_load", load_cnt, 0);
        check("no_resume_done", done_cnt, 0);
        spi_cs_n = 1'b1;
        wait_neg(12);
        run_vec(mk(8'h03, 8, 1, 0, 16'h0F0F, 16'h0, 16'h0, 16'hF00D, 16'h0, 16'h0, 4'h3, 1, 1, 2, 0));

        for (int i = 0; i < 20; i++) begin
            v.cb       = 8'($urandom);
            v.cmd_bits = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : 8;
            v.nw       = (v.cmd_bits == 8) ? $urandom_range(0, 3) : 0;
            v.cut      = (v.cmd_bits == 8 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
            for (int k = 0; k < 3; k++) v.w[k] = 16'($urandom);
            for (int k = 0; k < 4; k++) v.t[k] = 16'($urandom);
            v = model(v);
            run_vec(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
